// File: rtl/shared_pipe_arbiter.sv
// Round-robin, credit-gated arbiter feeding one shared non-stallable pipeline;
// a tag shadow register steers each pipeline result back to its requester.
module shared_pipe_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 16,
   parameter int PIPE_DEPTH = 4,
   parameter int CREDIT_MAX = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            req_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
   output logic [NUM_CH-1:0]            req_ready,
   input  logic [NUM_CH-1:0]            credit_return,
   output logic [DATA_WIDTH-1:0]        pipe_in_data,
   output logic                         pipe_in_valid,
   input  logic [DATA_WIDTH-1:0]        pipe_out_data,
   input  logic                         pipe_out_valid,
   output logic [DATA_WIDTH-1:0]        rsp_data,
   output logic [NUM_CH-1:0]            rsp_valid,
   output logic                         err
);
   // Handshake: a request on channel i is accepted on a rising clock edge when
   // req_valid[i] and req_ready[i] are both high; req_ready is one-hot or zero.
   localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CRW = 4;
   localparam int FW  = $clog2(PIPE_DEPTH + 2);

   logic [CW-1:0]         rr_ptr;
   logic [CRW-1:0]        credit [NUM_CH];
   logic [PIPE_DEPTH:0]   tag_v;
   logic [CW-1:0]         tag_ch [PIPE_DEPTH+1];
   logic [FW-1:0]         flush_cnt;

   logic [NUM_CH-1:0]     eligible;
   logic [CW-1:0]         scan_idx;
   logic [CW-1:0]         grant_idx;
   logic                  grant_any;
   logic [DATA_WIDTH-1:0] grant_data;
   logic                  credit_err;
   logic                  out_err;
   logic [NUM_CH-1:0]     rsp_onehot;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         eligible[i] = req_valid[i] && (credit[i] != '0);
      end
   end

   // Scan starts one past the last winner, wrapping at NUM_CH-1.
   always_comb begin
      scan_idx  = rr_ptr;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_idx = (scan_idx == CW'(NUM_CH - 1)) ? '0 : scan_idx + CW'(1);
         if (!grant_any && eligible[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
      req_ready = '0;
      if (grant_any && reset) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      grant_data = '0;
      credit_err = 1'b0;
      rsp_onehot = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req_ready[i]) begin
            grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
         if (credit_return[i] && !req_ready[i] && (credit[i] == CRW'(CREDIT_MAX))) begin
            credit_err = 1'b1;
         end
         rsp_onehot[i] = (tag_ch[PIPE_DEPTH] == CW'(i));
      end
      // Stale datapath valids are tolerated only while the post-reset flush runs.
      out_err = (flush_cnt == '0) && (pipe_out_valid != tag_v[PIPE_DEPTH]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr        <= CW'(NUM_CH - 1);
         tag_v         <= '0;
         flush_cnt     <= FW'(PIPE_DEPTH + 1);
         pipe_in_data  <= '0;
         pipe_in_valid <= 1'b0;
         rsp_data      <= '0;
         rsp_valid     <= '0;
         err           <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            credit[i] <= CRW'(CREDIT_MAX);
         end
         for (int k = 0; k <= PIPE_DEPTH; k++) begin
            tag_ch[k] <= '0;
         end
      end else begin
         pipe_in_valid <= grant_any;
         if (grant_any) begin
            pipe_in_data <= grant_data;
            rr_ptr       <= grant_idx;
         end
         tag_v     <= {tag_v[PIPE_DEPTH-1:0], grant_any};
         tag_ch[0] <= grant_idx;
         for (int k = 1; k <= PIPE_DEPTH; k++) begin
            tag_ch[k] <= tag_ch[k-1];
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (req_ready[i] && !credit_return[i]) begin
               credit[i] <= credit[i] - CRW'(1);
            end else if (!req_ready[i] && credit_return[i] &&
                         (credit[i] != CRW'(CREDIT_MAX))) begin
               credit[i] <= credit[i] + CRW'(1);
            end
         end
         if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FW'(1);
         end
         if (pipe_out_valid && tag_v[PIPE_DEPTH]) begin
            rsp_data  <= pipe_out_data;
            rsp_valid <= rsp_onehot;
         end else begin
            rsp_valid <= '0;
         end
         if (credit_err || out_err) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shared_pipe_arbiter.sv
// Bench for shared_pipe_arbiter: looped unreset datapath, credit/round-robin
// reference model, response scoreboard and sticky-error tracking.
module tb_shared_pipe_arbiter;
   localparam int NUM_CH = 4;
   localparam int DW     = 16;
   localparam int PD     = 4;
   localparam int CMAX   = 2;
   localparam int W      = 16 + NUM_CH + DW;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic [NUM_CH-1:0]      req_valid = '0;
   logic [NUM_CH*DW-1:0]   req_data = '0;
   logic [NUM_CH-1:0]      req_ready;
   logic [NUM_CH-1:0]      credit_return = '0;
   logic [DW-1:0]          pipe_in_data;
   logic                   pipe_in_valid;
   logic [DW-1:0]          pipe_out_data;
   logic                   pipe_out_valid;
   logic [DW-1:0]          rsp_data;
   logic [NUM_CH-1:0]      rsp_valid;
   logic                   err;

   logic                   inj_valid = 1'b0;
   logic [DW-1:0]          inj_data = '0;
   logic [DW-1:0]          dp_d [PD];
   logic [PD-1:0]          dp_v;

   int                     cred [NUM_CH];
   int                     last_g = NUM_CH - 1;
   int                     flush_left = PD + 1;
   logic                   err_exp = 1'b0;
   logic [W-1:0]           exp_q [$];
   int                     vectors = 0;
   int                     miscompares = 0;
   int                     cyc = 0;
   int                     dut_grants = 0;

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   shared_pipe_arbiter #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .PIPE_DEPTH(PD), .CREDIT_MAX(CMAX)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .credit_return(credit_return),
      .pipe_in_data(pipe_in_data), .pipe_in_valid(pipe_in_valid),
      .pipe_out_data(pipe_out_data), .pipe_out_valid(pipe_out_valid),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .err(err)
   );

   // Looped shared datapath: PD unreset stages, plus an injection override.
   always @(posedge clock) begin
      dp_v    <= {dp_v[PD-2:0], pipe_in_valid};
      dp_d[0] <= pipe_in_data;
      for (int k = 1; k < PD; k++) dp_d[k] <= dp_d[k-1];
   end
   assign pipe_out_valid = dp_v[PD-1] | inj_valid;
   assign pipe_out_data  = inj_valid ? inj_data : dp_d[PD-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NUM_CH*DW-1:0] rand_data();
      logic [NUM_CH*DW-1:0] d;
      for (int i = 0; i < NUM_CH; i++) d[i*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   // Round-robin choice: first requester with credit after the last winner.
   function automatic int model_pick(input logic [NUM_CH-1:0] rv);
      for (int k = 1; k <= NUM_CH; k++) begin
         int c;
         c = (last_g + k) % NUM_CH;
         if (rv[c] && cred[c] > 0) return c;
      end
      return -1;
   endfunction

   function automatic logic [NUM_CH-1:0] refill_mask();
      logic [NUM_CH-1:0] m;
      for (int i = 0; i < NUM_CH; i++) m[i] = (cred[i] < CMAX);
      return m;
   endfunction

   // One clock: drive inputs at the falling edge, predict the rising edge.
   task automatic step(input logic [NUM_CH-1:0] rv, input logic [NUM_CH-1:0] cr,
                       input logic inj, input logic [NUM_CH*DW-1:0] d);
      int g;
      logic [NUM_CH-1:0] exp_rdy;
      req_valid     = rv;
      credit_return = cr;
      req_data      = d;
      inj_valid     = inj;
      inj_data      = DW'($urandom);
      #1;
      g = model_pick(rv);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (req_ready != '0) dut_grants++;
      if (g >= 0) begin
         exp_q.push_back({16'(cyc + PD + 2), exp_rdy, d[g*DW +: DW]});
         last_g = g;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (cr[i]) begin
            if (g != i) begin
               if (cred[i] == CMAX) err_exp = 1'b1;
               else cred[i]++;
            end
         end else if (g == i) begin
            cred[i]--;
         end
      end
      if (inj && flush_left == 0) err_exp = 1'b1;
      if (flush_left > 0) flush_left--;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, 1'b0, rand_data());
   endtask

   task automatic refill();
      step('0, refill_mask(), 1'b0, rand_data());
   endtask

   task automatic do_reset(input int hold);
      #2;
      reset         = 1'b0;
      req_valid     = '1;
      credit_return = '0;
      inj_valid     = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NUM_CH; i++) cred[i] = CMAX;
      last_g     = NUM_CH - 1;
      flush_left = PD + 1;
      err_exp    = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, '0);
      chk("rst_pipe_in_valid", pipe_in_valid, 0);
      chk("rst_pipe_in_data", pipe_in_data, 0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_err", err, 0);
      req_valid = '0;
      repeat (hold) @(negedge clock);
      reset = 1'b1;
   endtask

   // Response monitor: pops the scoreboard whenever the DUT presents a result.
   always @(negedge clock) begin : monitor
      logic [W-1:0] e;
      if (rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, '0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, e[DW +: NUM_CH]);
            chk("rsp_data", rsp_data, e[DW-1:0]);
            chk("rsp_cycle", cyc, e[W-1 -: 16]);
         end
      end else if (exp_q.size() != 0 && int'(exp_q[0][W-1 -: 16]) <= cyc) begin
         e = exp_q.pop_front();
         chk("rsp_missing", rsp_valid, e[DW +: NUM_CH]);
      end
      chk("err", err, err_exp);
   end

   initial begin
      logic [NUM_CH*DW-1:0] d;
      logic [NUM_CH-1:0] cr;
      @(negedge clock);
      do_reset(4);

      // Single request on channel 2, looped straight back.
      d = rand_data();
      d[2*DW +: DW] = 16'h0123;
      step(4'b0100, '0, 1'b0, d);
      idle(PD + 3);

      // Fairness: all channels request, credits topped up every cycle.
      refill();
      dut_grants = 0;
      for (int s = 0; s < 16; s++) step(4'hF, refill_mask(), 1'b0, rand_data());
      chk("fair_grants", dut_grants, 16);
      idle(PD + 3);

      // Credit exhaustion on channel 0, then one returned credit.
      refill();
      dut_grants = 0;
      for (int s = 0; s < 4; s++) step(4'b0001, '0, 1'b0, rand_data());
      chk("exhaust_grants", dut_grants, 2);
      step(4'b0001, 4'b0001, 1'b0, rand_data());
      for (int s = 0; s < 3; s++) step(4'b0001, '0, 1'b0, rand_data());
      chk("return_grants", dut_grants, 3);
      idle(PD + 3);

      // Randomized traffic with random legal credit returns.
      refill();
      for (int s = 0; s < 400; s++) begin
         cr = refill_mask();
         for (int i = 0; i < NUM_CH; i++) if ($urandom_range(0, 2) != 0) cr[i] = 1'b0;
         step(4'($urandom_range(0, 15)), cr, 1'b0, rand_data());
      end
      idle(PD + 3);

      // Reset with three tokens in flight, stale valids during the flush.
      refill();
      for (int s = 0; s < 3; s++) step(4'b0111, '0, 1'b0, rand_data());
      do_reset(1);
      for (int s = 0; s < 5; s++) step('0, '0, 1'b1, rand_data());
      dut_grants = 0;
      for (int s = 0; s < 8; s++) step(4'hF, '0, 1'b0, rand_data());
      chk("post_reset_grants", dut_grants, 8);
      idle(PD + 3);

      // Grant plus return on channel 1 at credit 1, then overflow return.
      refill();
      step(4'b0010, '0, 1'b0, rand_data());
      step(4'b0010, 4'b0010, 1'b0, rand_data());
      step('0, 4'b0010, 1'b0, rand_data());
      step('0, 4'b0010, 1'b0, rand_data());
      idle(PD + 3);
      chk("err_sticky", err, 1);

      // Injected valid with an empty tag pipe after the flush.
      do_reset(2);
      idle(8);
      step('0, '0, 1'b1, rand_data());
      idle(3);
      chk("err_injected", err, 1);

      idle(PD + 3);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
